// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding,
// default sync bytes and the RAM byte-address composition.
package imem_loader_pkg;

    localparam int         DEF_DEPTH_WORDS = 256;
    localparam logic [7:0] DEF_SYNC_USER   = 8'hA5;
    localparam logic [7:0] DEF_SYNC_KERNEL = 8'hA6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CNT0 = 3'd1,
        ST_CNT1 = 3'd2,
        ST_DATA = 3'd3,
        ST_CHK  = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_e;

    // Byte address of word idx in the selected bank (bank lives in bit 31).
    function automatic logic [31:0] make_addr(input logic bank, input logic [7:0] idx);
        return {bank, 21'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian word assembler: shifts bytes in from the top so the first
// byte of a word ends in bits [7:0]. On the 4th byte the finished word is
// copied to a holding register and word_valid_o pulses for one cycle, so a
// byte arriving during that pulse can start the next word without
// disturbing the word being written.
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  lane_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  lane_q;
    logic [31:0] shift_q;
    logic [31:0] word_q;
    logic        word_valid_q;

    // Shift bytes in, count lanes, latch the complete word on lane 3.
    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q       <= 2'd0;
            shift_q      <= 32'd0;
            word_q       <= 32'd0;
            word_valid_q <= 1'b0;
        end else if (clear_i) begin
            lane_q       <= 2'd0;
            shift_q      <= 32'd0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            if (byte_valid_i) begin
                shift_q <= {byte_i, shift_q[31:8]};
                lane_q  <= lane_q + 2'd1;
                if (lane_q == 2'd3) begin
                    word_q       <= {byte_i, shift_q[31:8]};
                    word_valid_q <= 1'b1;
                end
            end
        end
    end

    assign lane_o       = lane_q;
    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses SYNC, CNT_LO, CNT_HI, then 4*CNT payload
// bytes from the UART receiver and writes little-endian words to the
// instruction RAM. Keeps the CPU held until a full image has arrived.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte that must match the payload for the load to succeed.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter logic [7:0] SYNC_USER   = DEF_SYNC_USER,
    parameter logic [7:0] SYNC_KERNEL = DEF_SYNC_KERNEL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);

    localparam logic [15:0] DEPTH_W = 16'(DEPTH_WORDS);

    // Handshake: rx_valid is a one-cycle strobe with no backpressure; every
    // strobed byte is consumed in its own cycle, including one that lands
    // in the same cycle as a RAM write.

    state_e      state_q;
    logic        bank_q;
    logic [7:0]  cnt_lo_q;
    logic [8:0]  words_left_q;
    logic [7:0]  idx_q;
    logic [31:0] wr_addr_q;
    logic        cpu_hold_q;
    logic        load_done_q;
    logic        load_err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  xor_q;
`endif

    logic        is_sync;
    logic        asm_clear;
    logic        asm_valid;
    logic [1:0]  asm_lane;
    logic        asm_word_valid;
    logic [31:0] asm_word;
    logic [15:0] cnt_full;

    assign is_sync   = (rx_data == SYNC_USER) || (rx_data == SYNC_KERNEL);
    assign asm_clear = (state_q == ST_IDLE) && rx_valid && is_sync;
    assign asm_valid = (state_q == ST_DATA) && rx_valid;
    assign cnt_full  = {rx_data, cnt_lo_q};

    word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (asm_clear),
        .byte_valid_i (asm_valid),
        .byte_i       (rx_data),
        .lane_o       (asm_lane),
        .word_valid_o (asm_word_valid),
        .word_o       (asm_word)
    );

    // Frame-parsing FSM with registered address and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bank_q       <= 1'b0;
            cnt_lo_q     <= 8'd0;
            words_left_q <= 9'd0;
            idx_q        <= 8'd0;
            wr_addr_q    <= 32'd0;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q        <= 8'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_valid && is_sync) begin
                        bank_q  <= (rx_data == SYNC_KERNEL);
                        idx_q   <= 8'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_q   <= 8'd0;
`endif
                        state_q <= ST_CNT0;
                    end
                end
                ST_CNT0: begin
                    if (rx_valid) begin
                        cnt_lo_q <= rx_data;
                        state_q  <= ST_CNT1;
                    end
                end
                ST_CNT1: begin
                    if (rx_valid) begin
                        if (cnt_full == 16'd0) begin
                            load_done_q <= 1'b1;
                            cpu_hold_q  <= 1'b0;
                            state_q     <= ST_DONE;
                        end else if (cnt_full > DEPTH_W) begin
                            load_err_q <= 1'b1;
                            state_q    <= ST_ERR;
                        end else begin
                            words_left_q <= cnt_full[8:0];
                            state_q      <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_q <= xor_q ^ rx_data;
`endif
                        if (asm_lane == 2'd3) begin
                            wr_addr_q    <= make_addr(bank_q, idx_q);
                            idx_q        <= idx_q + 8'd1;
                            words_left_q <= words_left_q - 9'd1;
                            if (words_left_q == 9'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state_q <= ST_CHK;
`else
                                state_q <= ST_DONE;
`endif
                            end
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (rx_valid) begin
                        if (rx_data == xor_q) begin
                            load_done_q <= 1'b1;
                            cpu_hold_q  <= 1'b0;
                            state_q     <= ST_DONE;
                        end else begin
                            load_err_q <= 1'b1;
                            state_q    <= ST_ERR;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    // Entered on the last payload byte; status rises one
                    // cycle later, i.e. just after the final write.
                    load_done_q <= 1'b1;
                    cpu_hold_q  <= 1'b0;
                end
                ST_ERR: begin
                    load_err_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_en     = asm_word_valid;
    assign wr_data   = asm_word;
    assign wr_addr   = wr_addr_q;
    assign cpu_hold  = cpu_hold_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frame parsing, write timing, bank
// selection, empty and oversized images, junk bytes, back-to-back bytes,
// reset mid-load and (when IMEM_LOADER_CHECKSUM_EN is defined) checksum.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    int vectors;
    int errors;
    int n_writes;

    // Scoreboard of expected writes, {addr, data}.
    logic [63:0] exp_q[$];

    imem_loader dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every RAM write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && wr_en === 1'b1) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {wr_addr, wr_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("write", {wr_addr, wr_data}, exp_q.pop_front());
            end
        end
    end

    // Drivers (called at a falling edge; consecutive calls are back-to-back).
    task automatic put(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vectors  = 0;
        errors   = 0;
        n_writes = 0;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_wr_en",     64'(wr_en),     64'd0);
        check("rst_wr_addr",   64'(wr_addr),   64'd0);
        check("rst_wr_data",   64'(wr_data),   64'd0);
        check("rst_cpu_hold",  64'(cpu_hold),  64'd1);
        check("rst_load_done", 64'(load_done), 64'd0);
        check("rst_load_err",  64'(load_err),  64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Junk then a two-word user frame; byte 22 lands in the write cycle.
        exp_q.push_back({32'h0000_0000, 32'h2001_0014});
        exp_q.push_back({32'h0000_0004, 32'h003D_E822});
        put(8'h00); put(8'hFF);
        put(8'hA5); put(8'h02); put(8'h00);
        put(8'h14); put(8'h00); put(8'h01); put(8'h20);
        check("t1_w0_wr_en", 64'(wr_en), 64'd1);
        put(8'h22);
        check("t1_gap_wr_en", 64'(wr_en), 64'd0);
        put(8'hE8); put(8'h3D); put(8'h00);
        check("t1_w1_wr_en",     64'(wr_en),     64'd1);
        check("t1_w1_load_done", 64'(load_done), 64'd0);
        check("t1_w1_cpu_hold",  64'(cpu_hold),  64'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        put(8'hC2);
`else
        @(negedge clk);
`endif
        check("t1_load_done", 64'(load_done), 64'd1);
        check("t1_cpu_hold",  64'(cpu_hold),  64'd0);
        check("t1_wr_en_off", 64'(wr_en),     64'd0);
        check("t1_writes",    64'(n_writes),  64'd2);

        // DONE is terminal: a further frame is ignored.
        put(8'hA5); put(8'h01); put(8'h00);
        put(8'h11); put(8'h22); put(8'h33); put(8'h44);
        repeat (2) @(negedge clk);
        check("t1_ignored_writes", 64'(n_writes),  64'd2);
        check("t1_done_sticky",    64'(load_done), 64'd1);

        do_reset();
        check("t2_rst_load_done", 64'(load_done), 64'd0);
        check("t2_rst_cpu_hold",  64'(cpu_hold),  64'd1);

        // Kernel bank, single word.
        exp_q.push_back({32'h8000_0000, 32'h1234_5678});
        put(8'hA6); put(8'h01); put(8'h00);
        put(8'h78); put(8'h56); put(8'h34); put(8'h12);
        check("t2_wr_en", 64'(wr_en), 64'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        put(8'h08);
`else
        @(negedge clk);
`endif
        check("t2_load_done", 64'(load_done), 64'd1);
        check("t2_writes",    64'(n_writes),  64'd3);

        // Empty image: done one cycle after CNT_HI.
        do_reset();
        put(8'hA5); put(8'h00);
        check("t3_before_done", 64'(load_done), 64'd0);
        put(8'h00);
        check("t3_load_done", 64'(load_done), 64'd1);
        check("t3_cpu_hold",  64'(cpu_hold),  64'd0);
        check("t3_load_err",  64'(load_err),  64'd0);
        repeat (2) @(negedge clk);
        check("t3_writes", 64'(n_writes), 64'd3);

        // Oversized image (CNT=257): error, later bytes ignored.
        do_reset();
        put(8'hA5); put(8'h01); put(8'h01);
        check("t4_load_err",  64'(load_err),  64'd1);
        check("t4_cpu_hold",  64'(cpu_hold),  64'd1);
        check("t4_load_done", 64'(load_done), 64'd0);
        put(8'h00); put(8'h00); put(8'hA5); put(8'h01); put(8'h00);
        put(8'hAA); put(8'hBB); put(8'hCC); put(8'hDD);
        repeat (2) @(negedge clk);
        check("t4_err_sticky", 64'(load_err),  64'd1);
        check("t4_hold_kept",  64'(cpu_hold),  64'd1);
        check("t4_writes",     64'(n_writes),  64'd3);

        // Boundary: CNT=256 is accepted (no error after CNT_HI).
        do_reset();
        put(8'hA5); put(8'h00); put(8'h01);
        check("t4b_cnt256_err", 64'(load_err), 64'd0);

        // Reset mid-load, then a full frame restarts at address 0.
        do_reset();
        put(8'hA5); put(8'h02); put(8'h00); put(8'h11); put(8'h22);
        do_reset();
        exp_q.push_back({32'h0000_0000, 32'hEFBE_ADDE});
        put(8'hA5); put(8'h01); put(8'h00);
        put(8'hDE); put(8'hAD); put(8'hBE); put(8'hEF);
        check("t6_wr_en", 64'(wr_en), 64'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        put(8'h22);
`else
        @(negedge clk);
`endif
        check("t6_load_done", 64'(load_done), 64'd1);
        check("t6_writes",    64'(n_writes),  64'd4);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong checksum: word still written, then error.
        do_reset();
        exp_q.push_back({32'h0000_0000, 32'h0403_0201});
        put(8'hA5); put(8'h01); put(8'h00);
        put(8'h01); put(8'h02); put(8'h03); put(8'h04);
        put(8'h05);
        check("t7_load_err",  64'(load_err),  64'd1);
        check("t7_load_done", 64'(load_done), 64'd0);
        check("t7_cpu_hold",  64'(cpu_hold),  64'd1);
`endif

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
